c_frag_share_sched: RTL and testbench

- Round-robin scheduler that time-shares one C_FRAG_MODES logic cell among NREQ requesters.
- Each request is a set of C_FRAG routing-input values. The block registers the winning request onto the cell's inputs, then captures TZ/CZ one cycle later as a tagged response.
- In SPLIT mode it co-issues two requests per cycle: one to the T half and one to the B half.
- Sits between soft requesters and a hard C_FRAG_MODES instance; it contains no logic-function state of its own.

---
 rtl/c_frag_share_sched.sv | 131 +++++++++++++
 tb/tb_c_frag_share_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c_frag_share_sched.sv
// Round-robin scheduler time-sharing one C_FRAG_MODES cell among NREQ requesters (SPLIT co-issues T/B halves).
// Latency: accept at edge N drives frag_in after N, tagged TZ/CZ response visible after N+1.
// Backpressure: a held response (rsp_valid && !rsp_ready) freezes both stages and drops every req_ready.
module c_frag_share_sched #(
    parameter int    NREQ = 4,
    parameter int    IDW  = 2,
    parameter string MODE = "SINGLE"
) (
    input  logic                QCK,
    input  logic                QRN,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*13-1:0]  req_data,
    output logic [12:0]         frag_in,
    input  logic                frag_tz,
    input  logic                frag_cz,
    output logic [1:0]          rsp_valid,
    output logic [2*IDW-1:0]    rsp_id,
    output logic [1:0]          rsp_z,
    input  logic                rsp_ready
);

    localparam bit SPLIT = (MODE == "SPLIT");

    logic [12:0]      req_dat [NREQ];
    logic [IDW-1:0]   rr_ptr;
    logic [1:0]       iss_vld;
    logic [2*IDW-1:0] iss_id;

    logic             stall;
    logic             prim_fnd;
    logic [IDW-1:0]   prim_id;
    logic             prim_tbs;
    logic             sec_fnd;
    logic [IDW-1:0]   sec_id;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   nxt_ptr;
    logic [12:0]      nxt_frag;
    logic [NREQ-1:0]  gnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_dat[g] = req_data[13*g +: 13];
    end

    assign stall = (|rsp_valid) && !rsp_ready;

    // Two-pass priority: lowest valid index at/above the pointer, else lowest overall (the wrap).
    always_comb begin
        prim_fnd = 1'b0;
        prim_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!prim_fnd && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
                prim_fnd = 1'b1;
                prim_id  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!prim_fnd && req_valid[i]) begin
                prim_fnd = 1'b1;
                prim_id  = IDW'(i);
            end
        end
    end

    assign prim_tbs = req_dat[prim_id][12];

    // B-half partner: next valid requester after the primary sharing its TBS; never the primary itself.
    always_comb begin
        sec_fnd = 1'b0;
        sec_id  = '0;
        if (SPLIT && prim_fnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!sec_fnd && req_valid[i] && (IDW'(i) > prim_id) &&
                    (req_dat[i][12] == prim_tbs)) begin
                    sec_fnd = 1'b1;
                    sec_id  = IDW'(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!sec_fnd && req_valid[i] && (IDW'(i) < prim_id) &&
                    (req_dat[i][12] == prim_tbs)) begin
                    sec_fnd = 1'b1;
                    sec_id  = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (prim_fnd && (prim_id == IDW'(i))) || (sec_fnd && (sec_id == IDW'(i)));
        end
    end

    assign req_ready = (QRN && !stall) ? gnt : '0;

    assign last_id = sec_fnd ? sec_id : prim_id;
    assign nxt_ptr = (last_id == IDW'(NREQ - 1)) ? '0 : last_id + 1'b1;

    always_comb begin
        nxt_frag = req_dat[prim_id];
        if (SPLIT) begin
            nxt_frag[5:0] = sec_fnd ? req_dat[sec_id][5:0] : 6'b0;
        end
    end

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            frag_in   <= '0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rr_ptr    <= '0;
            iss_vld   <= '0;
            iss_id    <= '0;
        end else if (!stall) begin
            rsp_valid <= iss_vld;
            rsp_id    <= iss_id;
            rsp_z     <= {(SPLIT ? frag_cz : 1'b0), frag_tz};
            iss_vld   <= {sec_fnd, prim_fnd};
            // frag_in keeps its last value when idle so the cell inputs do not toggle.
            if (prim_fnd) begin
                frag_in <= nxt_frag;
                iss_id  <= {(sec_fnd ? sec_id : IDW'(0)), prim_id};
                rr_ptr  <= nxt_ptr;
            end
        end
    end

endmodule

// File: tb/tb_c_frag_share_sched.sv
// Directed bench: one SINGLE and one SPLIT scheduler in front of a parity-based model of the cell.
module tb_c_frag_share_sched;

    logic        QCK;
    logic        QRN;
    logic        rsp_ready;

    logic [3:0]  req_valid, req_ready;
    logic [51:0] req_data;
    logic [12:0] frag_in;
    logic        frag_tz, frag_cz;
    logic [1:0]  rsp_valid, rsp_z;
    logic [3:0]  rsp_id;

    logic [3:0]  s_req_valid, s_req_ready;
    logic [51:0] s_req_data;
    logic [12:0] s_frag_in;
    logic        s_frag_tz, s_frag_cz;
    logic [1:0]  s_rsp_valid, s_rsp_z;
    logic [3:0]  s_rsp_id;

    logic [12:0] dat   [4];
    logic [12:0] s_dat [4];

    int checks;
    int failures;

    function automatic logic tzf(input logic [12:0] f);
        return ^f[12:6];
    endfunction

    function automatic logic czf(input logic [12:0] f);
        return ^f[5:0];
    endfunction

    assign frag_tz   = tzf(frag_in);
    assign frag_cz   = czf(frag_in);
    assign s_frag_tz = tzf(s_frag_in);
    assign s_frag_cz = czf(s_frag_in);
    assign req_data   = {dat[3], dat[2], dat[1], dat[0]};
    assign s_req_data = {s_dat[3], s_dat[2], s_dat[1], s_dat[0]};

    c_frag_share_sched #(.NREQ(4), .IDW(2), .MODE("SINGLE")) u_single (
        .QCK(QCK), .QRN(QRN),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .frag_in(frag_in), .frag_tz(frag_tz), .frag_cz(frag_cz),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready)
    );

    c_frag_share_sched #(.NREQ(4), .IDW(2), .MODE("SPLIT")) u_split (
        .QCK(QCK), .QRN(QRN),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_data(s_req_data),
        .frag_in(s_frag_in), .frag_tz(s_frag_tz), .frag_cz(s_frag_cz),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_z(s_rsp_z), .rsp_ready(rsp_ready)
    );

    initial begin
        QCK = 1'b0;
        forever #5 QCK = ~QCK;
    end

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic do_reset();
        req_valid   = '0;
        s_req_valid = '0;
        rsp_ready   = 1'b1;
        QRN = 1'b0;
        #2;
        QRN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        QRN = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        s_req_valid = 4'hF;
        #2;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (s_req_ready !== 4'b0) begin failures++; $display("FAIL reset_split_req_ready got=%b exp=0000", s_req_ready); end
        tick();
        tick();
        checks++; if (frag_in !== 13'h0) begin failures++; $display("FAIL reset_frag_in got=%h exp=0", frag_in); end
        checks++; if (rsp_valid !== 2'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_id !== 4'h0) begin failures++; $display("FAIL reset_rsp_id got=%h exp=0", rsp_id); end
        checks++; if (rsp_z !== 2'b0) begin failures++; $display("FAIL reset_rsp_z got=%b exp=00", rsp_z); end
        checks++; if (s_frag_in !== 13'h0) begin failures++; $display("FAIL reset_split_frag_in got=%h exp=0", s_frag_in); end
        req_valid = '0;
        s_req_valid = '0;
        QRN = 1'b1;
        #1;
    endtask

    task automatic test_single_basic();
        logic exp_z;
        exp_z = tzf(13'h1ABC);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL basic_req_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (frag_in !== 13'h1ABC) begin failures++; $display("FAIL basic_frag_in got=%h exp=1abc", frag_in); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL basic_rsp_early got=%b exp=00", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL basic_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_id[1:0] !== 2'd2) begin failures++; $display("FAIL basic_rsp_id got=%0d exp=2", rsp_id[1:0]); end
        checks++; if (rsp_z[0] !== exp_z) begin failures++; $display("FAIL basic_rsp_z got=%b exp=%b", rsp_z[0], exp_z); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL idle_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (frag_in !== 13'h1ABC) begin failures++; $display("FAIL idle_frag_hold got=%h exp=1abc", frag_in); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            #1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
            tick();
            checks++; if (frag_in !== dat[k % 4]) begin failures++; $display("FAIL rr_frag[%0d] got=%h exp=%h", k, frag_in, dat[k % 4]); end
            if (k > 0) begin
                checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=01", k, rsp_valid); end
                checks++; if (rsp_id[1:0] !== 2'((k - 1) % 4)) begin failures++; $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", k, rsp_id[1:0], (k - 1) % 4); end
                checks++; if (rsp_z[0] !== tzf(dat[(k - 1) % 4])) begin failures++; $display("FAIL rr_rsp_z[%0d] got=%b exp=%b", k, rsp_z[0], tzf(dat[(k - 1) % 4])); end
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready_drop got=%b exp=0000", req_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (frag_in !== dat[3]) begin failures++; $display("FAIL bp_frag[%0d] got=%h exp=%h", c, frag_in, dat[3]); end
            checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=01", c, rsp_valid); end
            checks++; if (rsp_id[1:0] !== 2'd2) begin failures++; $display("FAIL bp_rsp_id[%0d] got=%0d exp=2", c, rsp_id[1:0]); end
            checks++; if (rsp_z[0] !== tzf(dat[2])) begin failures++; $display("FAIL bp_rsp_z[%0d] got=%b exp=%b", c, rsp_z[0], tzf(dat[2])); end
            checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_resume_ready got=%b exp=0001", req_ready); end
        tick();
        checks++; if (rsp_id[1:0] !== 2'd3) begin failures++; $display("FAIL bp_resume_id got=%0d exp=3", rsp_id[1:0]); end
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_resume_valid got=%b exp=01", rsp_valid); end
        checks++; if (frag_in !== dat[0]) begin failures++; $display("FAIL bp_resume_frag got=%h exp=%h", frag_in, dat[0]); end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        QRN = 1'b0;
        #1;
        checks++; if (frag_in !== 13'h0) begin failures++; $display("FAIL arst_frag got=%h exp=0", frag_in); end
        checks++; if (rsp_valid !== 2'b0) begin failures++; $display("FAIL arst_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_id !== 4'h0) begin failures++; $display("FAIL arst_rsp_id got=%h exp=0", rsp_id); end
        checks++; if (rsp_z !== 2'b0) begin failures++; $display("FAIL arst_rsp_z got=%b exp=00", rsp_z); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL arst_req_ready got=%b exp=0000", req_ready); end
        #1;
        QRN = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL arst_first_grant got=%b exp=0001", req_ready); end
        tick();
        checks++; if (frag_in !== dat[0]) begin failures++; $display("FAIL arst_frag_after got=%h exp=%h", frag_in, dat[0]); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL arst_no_replay got=%b exp=00", rsp_valid); end
        req_valid = '0;
    endtask

    task automatic test_split_pair();
        do_reset();
        s_dat[0] = 13'h1573;
        s_dat[1] = 13'h1E0E;
        s_dat[2] = 13'h0ABC;
        s_dat[3] = 13'h1F01;
        s_req_valid = 4'b0011;
        #1;
        checks++; if (s_req_ready !== 4'b0011) begin failures++; $display("FAIL pair_ready got=%b exp=0011", s_req_ready); end
        tick();
        checks++; if (s_frag_in !== 13'h154E) begin failures++; $display("FAIL pair_frag got=%h exp=154e", s_frag_in); end
        s_req_valid = 4'hF;
        #1;
        checks++; if (s_req_ready !== 4'b0100) begin failures++; $display("FAIL pair_next_ready got=%b exp=0100", s_req_ready); end
        tick();
        s_req_valid = '0;
        checks++; if (s_rsp_valid !== 2'b11) begin failures++; $display("FAIL pair_rsp_valid got=%b exp=11", s_rsp_valid); end
        checks++; if (s_rsp_id !== 4'b0100) begin failures++; $display("FAIL pair_rsp_id got=%b exp=0100", s_rsp_id); end
        checks++; if (s_rsp_z !== {czf(13'h154E), tzf(13'h154E)}) begin failures++; $display("FAIL pair_rsp_z got=%b exp=%b%b", s_rsp_z, czf(13'h154E), tzf(13'h154E)); end
        checks++; if (s_frag_in !== 13'h0A80) begin failures++; $display("FAIL pair_solo_frag got=%h exp=0a80", s_frag_in); end
        tick();
        checks++; if (s_rsp_valid !== 2'b01) begin failures++; $display("FAIL pair_solo_valid got=%b exp=01", s_rsp_valid); end
        checks++; if (s_rsp_id[1:0] !== 2'd2) begin failures++; $display("FAIL pair_solo_id got=%0d exp=2", s_rsp_id[1:0]); end
    endtask

    task automatic test_split_incompat();
        do_reset();
        s_dat[0] = 13'h0155;
        s_dat[1] = 13'h1E0E;
        s_req_valid = 4'b0011;
        #1;
        checks++; if (s_req_ready !== 4'b0001) begin failures++; $display("FAIL incompat_ready0 got=%b exp=0001", s_req_ready); end
        tick();
        checks++; if (s_frag_in !== 13'h0140) begin failures++; $display("FAIL incompat_frag0 got=%h exp=0140", s_frag_in); end
        s_req_valid = 4'b0010;
        #1;
        checks++; if (s_req_ready !== 4'b0010) begin failures++; $display("FAIL incompat_ready1 got=%b exp=0010", s_req_ready); end
        tick();
        s_req_valid = '0;
        checks++; if (s_frag_in !== 13'h1E00) begin failures++; $display("FAIL incompat_frag1 got=%h exp=1e00", s_frag_in); end
        checks++; if (s_rsp_valid !== 2'b01) begin failures++; $display("FAIL incompat_valid0 got=%b exp=01", s_rsp_valid); end
        checks++; if (s_rsp_id[1:0] !== 2'd0) begin failures++; $display("FAIL incompat_id0 got=%0d exp=0", s_rsp_id[1:0]); end
        checks++; if (s_rsp_z[0] !== tzf(13'h0140)) begin failures++; $display("FAIL incompat_z0 got=%b exp=%b", s_rsp_z[0], tzf(13'h0140)); end
        tick();
        checks++; if (s_rsp_valid !== 2'b01) begin failures++; $display("FAIL incompat_valid1 got=%b exp=01", s_rsp_valid); end
        checks++; if (s_rsp_id[1:0] !== 2'd1) begin failures++; $display("FAIL incompat_id1 got=%0d exp=1", s_rsp_id[1:0]); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dat[0] = 13'h0A51;
        dat[1] = 13'h1234;
        dat[2] = 13'h1ABC;
        dat[3] = 13'h0F0F;
        for (int i = 0; i < 4; i++) s_dat[i] = '0;
        test_reset();
        test_single_basic();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_split_pair();
        test_split_incompat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
